// File: rtl/twi_sched_pkg.sv
// Shared types and register map for the I2C command scheduler.
// Command encodings, FSM states, register offsets and bit positions.
package twi_sched_pkg;

   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2,
      OP_STOP  = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_STOP_ISSUE,
      S_STOP_WAIT
   } sched_state_e;

   localparam logic [7:0] REG_CTRL   = 8'h00;
   localparam logic [7:0] REG_CMD    = 8'h04;
   localparam logic [7:0] REG_STATUS = 8'h08;
   localparam logic [7:0] REG_RXDATA = 8'h0C;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_ABORT  = 2;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_NACK  = 3;
   localparam int STAT_DONE  = 4;
   localparam int STAT_OVF   = 5;
   localparam int STAT_COUNT = 8;

   localparam int RX_VALID_BIT = 8;
   localparam int FIFO_ENTRY_W = 10;

   // Unpacks the opcode field of a queued {op, byte} entry.
   function automatic cmd_op_e entry_op(input logic [FIFO_ENTRY_W-1:0] entry);
      return cmd_op_e'(entry[9:8]);
   endfunction

endpackage

// File: rtl/twi_cmd_fifo.sv
// Synchronous command FIFO holding {op, byte} entries.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module twi_cmd_fifo
   import twi_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [FIFO_ENTRY_W-1:0] din,
   output logic [FIFO_ENTRY_W-1:0] head,
   output logic [PTR_W:0]          count,
   output logic                    full,
   output logic                    empty
);

   logic [FIFO_ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic                    pop_ok;
   logic                    push_ok;

   assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      end
   end

endmodule

// File: rtl/twi_cmd_scheduler.sv
// Register file, command FSM and RX capture sitting between apb_slave and the
// I2C byte engine; issues queued commands one at a time with NACK recovery.
module twi_cmd_scheduler
   import twi_sched_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 8,
   parameter int APB_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [APB_ADDR_WIDTH-1:0] addr,
   input  logic [APB_DATA_WIDTH-1:0] wr_data,
   output logic [APB_DATA_WIDTH-1:0] rd_data,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [1:0]                cmd_op,
   output logic [7:0]                cmd_byte,
   input  logic                      eng_done,
   input  logic                      eng_nack,
   input  logic [7:0]                eng_rx_byte,
   output logic                      irq
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   sched_state_e            state;
   cmd_op_e                 cmd_op_q;
   logic                    ctrl_en;
   logic                    ctrl_irq_en;
   logic                    stat_nack;
   logic                    stat_done;
   logic                    stat_ovf;
   logic                    rx_valid;
   logic [7:0]              rx_byte;
   logic                    abort_pend;

   logic [FIFO_ENTRY_W-1:0] fifo_head;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_flush;

   logic                    ctrl_wr;
   logic                    cmd_wr;
   logic                    status_wr;
   logic                    rx_rd;
   logic                    abort;
   logic                    nack_evt;
   logic [31:0]             rd_word;
   logic                    unused_wr_bits;

   assign ctrl_wr   = wr_en && (addr == APB_ADDR_WIDTH'(REG_CTRL));
   assign cmd_wr    = wr_en && (addr == APB_ADDR_WIDTH'(REG_CMD));
   assign status_wr = wr_en && (addr == APB_ADDR_WIDTH'(REG_STATUS));
   assign rx_rd     = rd_en && (addr == APB_ADDR_WIDTH'(REG_RXDATA));
   assign abort     = ctrl_wr && wr_data[CTRL_ABORT];

   assign nack_evt   = (state == S_WAIT) && eng_done && eng_nack && (cmd_op_q == OP_WRITE);
   assign fifo_push  = cmd_wr;
   assign fifo_pop   = (state == S_ISSUE) && cmd_valid && cmd_ready;
   assign fifo_flush = abort || nack_evt;

   assign cmd_op = cmd_op_q;
   assign irq    = stat_done & ctrl_irq_en;

   assign unused_wr_bits = ^wr_data[APB_DATA_WIDTH-1:FIFO_ENTRY_W];

   twi_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (pclk),
      .rst   (preset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (wr_data[FIFO_ENTRY_W-1:0]),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      rd_word = '0;
      if (addr == APB_ADDR_WIDTH'(REG_CTRL)) begin
         rd_word[CTRL_EN]     = ctrl_en;
         rd_word[CTRL_IRQ_EN] = ctrl_irq_en;
      end else if (addr == APB_ADDR_WIDTH'(REG_STATUS)) begin
         rd_word[STAT_BUSY]         = (state != S_IDLE);
         rd_word[STAT_FULL]         = fifo_full;
         rd_word[STAT_EMPTY]        = fifo_empty;
         rd_word[STAT_NACK]         = stat_nack;
         rd_word[STAT_DONE]         = stat_done;
         rd_word[STAT_OVF]          = stat_ovf;
         rd_word[STAT_COUNT +: 4]   = 4'(fifo_count);
      end else if (addr == APB_ADDR_WIDTH'(REG_RXDATA)) begin
         rd_word[7:0]          = rx_byte;
         rd_word[RX_VALID_BIT] = rx_valid;
      end
   end

   assign rd_data = APB_DATA_WIDTH'(rd_word);

   // Flag clears come first so that any set later in this block wins the same edge.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state       <= S_IDLE;
         cmd_valid   <= 1'b0;
         cmd_op_q    <= OP_START;
         cmd_byte    <= '0;
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         stat_nack   <= 1'b0;
         stat_done   <= 1'b0;
         stat_ovf    <= 1'b0;
         rx_valid    <= 1'b0;
         rx_byte     <= '0;
         abort_pend  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ctrl_en     <= wr_data[CTRL_EN];
            ctrl_irq_en <= wr_data[CTRL_IRQ_EN];
         end
         if (status_wr) begin
            stat_nack <= stat_nack & ~wr_data[STAT_NACK];
            stat_done <= stat_done & ~wr_data[STAT_DONE];
            stat_ovf  <= stat_ovf  & ~wr_data[STAT_OVF];
         end
         if (rx_rd) rx_valid <= 1'b0;
         if (fifo_push && fifo_full && !fifo_pop) stat_ovf <= 1'b1;

         case (state)
            S_IDLE: begin
               if (ctrl_en && !fifo_empty && !abort) begin
                  cmd_op_q  <= entry_op(fifo_head);
                  cmd_byte  <= fifo_head[7:0];
                  cmd_valid <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (abort) begin
                  cmd_valid <= 1'b0;
                  state     <= S_IDLE;
               end else if (cmd_valid && cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (abort) abort_pend <= 1'b1;
               if (eng_done) begin
                  abort_pend <= 1'b0;
                  if (cmd_op_q == OP_READ) begin
                     rx_byte  <= eng_rx_byte;
                     rx_valid <= 1'b1;
                  end
                  if (nack_evt || abort || abort_pend) begin
                     if (nack_evt) stat_nack <= 1'b1;
                     cmd_op_q  <= OP_STOP;
                     cmd_byte  <= '0;
                     cmd_valid <= 1'b1;
                     state     <= S_STOP_ISSUE;
                  end else if (ctrl_en && !fifo_empty) begin
                     cmd_op_q  <= entry_op(fifo_head);
                     cmd_byte  <= fifo_head[7:0];
                     cmd_valid <= 1'b1;
                     state     <= S_ISSUE;
                  end else begin
                     // A cleared enable parks the sequence without reporting completion.
                     if (ctrl_en) stat_done <= 1'b1;
                     state <= S_IDLE;
                  end
               end
            end
            S_STOP_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= S_STOP_WAIT;
               end
            end
            S_STOP_WAIT: begin
               if (eng_done) begin
                  stat_done <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               cmd_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/twi_cmd_scheduler.md
# twi_cmd_scheduler

Command scheduler for the APB I2C master. Sits behind `apb_slave`, decoding its `wr_en`/`rd_en`/`addr`/`wr_data` strobes into a small register file, and queues START/WRITE/READ/STOP commands in a FIFO. It issues those commands one at a time to the I2C byte engine over a valid/ready + done handshake, and returns register read data on `rd_data`. It handles NACK recovery (auto STOP plus flush) and raises a completion interrupt.

## Interface
- `APB_ADDR_WIDTH`, default 8: register address width.
- `APB_DATA_WIDTH`, default 32: register data width.
- `FIFO_DEPTH`, default 4: command FIFO entries, power of two, ≥2.
- `pclk  in  1`: clock. One clock domain for the whole block.
- `preset  in  1`: reset, asynchronous and active-high.
- `wr_en  in  1`: register write strobe from `apb_slave`, one cycle per transfer.
- `rd_en  in  1`: register read strobe from `apb_slave`, one cycle per transfer.
- `addr  in  APB_ADDR_WIDTH`: register byte address.
- `wr_data  in  APB_DATA_WIDTH`: write data.
- `rd_data  out  APB_DATA_WIDTH`: read data, combinational from `addr`.
- `cmd_valid  out  1`: command offered to the byte engine.
- `cmd_ready  in  1`: byte engine accepts the command.
- `cmd_op  out  2`: 0=START, 1=WRITE, 2=READ, 3=STOP.
- `cmd_byte  out  8`: TX byte for WRITE; don't-care otherwise.
- `eng_done  in  1`: one-cycle pulse when the accepted command has finished.
- `eng_nack  in  1`: valid with `eng_done`; the slave NACKed a WRITE.
- `eng_rx_byte  in  8`: valid with `eng_done` for a READ.
- `irq  out  1`: level interrupt, equal to `STATUS.done & CTRL.irq_en`.

## Operation
- Registers (offsets; unmapped reads return 0; unmapped writes are ignored):
  - 0x00 CTRL, RW: bit0 `en`, bit1 `irq_en`; bit2 `abort` is write-only and reads as 0.
  - 0x04 CMD, WO: push `{op=wr_data[9:8], byte=wr_data[7:0]}` into the FIFO.
  - 0x08 STATUS, RO unless noted:
    - bit0 `busy`: FSM not in IDLE.
    - bit1 `full`, bit2 `empty`.
    - bit3 `nack`, W1C.
    - bit4 `done`, W1C.
    - bit5 `ovf`, W1C.
    - bits[8+:4] FIFO count.
  - 0x0C RXDATA, RO: [7:0] last received byte, bit8 `rx_valid`. A read with `rd_en` clears `rx_valid` on the next edge.
- A push while the FIFO is full is dropped and sets `ovf`. Exception: a push and a pop in the same cycle are both accepted, and the count is unchanged.
- FSM states: IDLE, ISSUE, WAIT, STOP_ISSUE, STOP_WAIT.
  - IDLE → ISSUE when `en=1` and the FIFO is not empty.
  - ISSUE drives `cmd_valid` with the FIFO head. When `cmd_valid & cmd_ready`, it pops the head and goes to WAIT.
  - WAIT on `eng_done`:
    - For a READ, capture `eng_rx_byte` and set `rx_valid`. If `rx_valid` was already 1, the byte is overwritten.
    - If `eng_nack` on a WRITE: set `nack`, flush the FIFO, go to STOP_ISSUE.
    - Otherwise, if the FIFO is not empty and `en=1`, go to ISSUE.
    - Otherwise set `done` and go to IDLE.
  - STOP_ISSUE drives `cmd_op=STOP`; on the handshake, go to STOP_WAIT.
  - STOP_WAIT on `eng_done`: set `done`, go to IDLE. `eng_nack` is ignored here.
- Abort (CTRL write with bit2=1):
  - Flushes the FIFO on the next edge.
  - In IDLE: no effect beyond the flush.
  - In ISSUE: `cmd_valid` drops and the FSM goes to IDLE with no STOP.
  - In WAIT: the current command completes, then the FSM goes to STOP_ISSUE.
- Clearing `en` mid-sequence: the in-flight command completes, then the FSM goes to IDLE without setting `done`, and the queued entries are retained.
- If a W1C clear and a set of the same flag occur in the same cycle, the set wins.

## Timing
- Reset values: `rd_data` reflects the reset registers; `cmd_valid=0`, `cmd_op=0`, `cmd_byte=0`, `irq=0`.
  - CTRL=0.
  - FIFO empty, so STATUS reads 0x4.
  - RXDATA=0.
  - FSM in IDLE.
- `preset` asynchronously clears all state, including mid-handshake. `cmd_valid` falls with reset.
- Register writes take effect on the `pclk` edge at which `wr_en` is high.
- Push-to-`cmd_valid` latency from an idle, enabled state:
  - Edge N: the push is written.
  - Edge N+1: the FSM enters ISSUE.
  - `cmd_valid` is high from N+1, so the latency is 1 cycle.
- `cmd_valid` is registered. `cmd_op`/`cmd_byte` are held stable while valid and not ready.
- Done-to-next-`cmd_valid`: 1 cycle (WAIT→ISSUE on the `eng_done` edge).
- `eng_done` outside WAIT or STOP_WAIT is ignored.

## Structure
- Package `twi_sched_pkg`:
  - `cmd_op_e` enum.
  - State enum `sched_state_e`.
  - Register offset localparams: `REG_CTRL`, `REG_CMD`, `REG_STATUS`, `REG_RXDATA`.
  - STATUS/CTRL bit-index constants.
- Sub-module `twi_cmd_fifo`:
  - Synchronous FIFO, 10-bit entries, parameter `FIFO_DEPTH`.
  - Ports: push, pop, flush, head, count, full, empty.
  - Pointers wrap modulo depth.
- Top level holds the register decode, the FSM and the RX capture.

## Test plan
- Reset, then read 0x08 → 0x4, and read 0x00 → 0. During reset, `cmd_valid=0` and `irq=0`.
- Program CTRL=0x3, then push START, WRITE 0xA0, WRITE 0x55, STOP with `cmd_ready` tied high and `eng_done` 2 cycles after each accept:
  - Expect 4 handshakes in order with bytes 0xA0/0x55.
  - Then STATUS.done=1 and `irq=1`.
  - Writing 0x10 to 0x08 clears `irq` on the next edge.
- Push START, WRITE 0x42, READ, STOP, where the engine returns 0x3C on the READ: RXDATA reads 0x13C; the next read returns 0x03C.
- With `en=0`, perform 5 pushes at FIFO_DEPTH=4 → count=4, full=1, ovf=1; the fifth entry is absent after enabling.
- Return NACK on WRITE 0xA0 with 2 commands still queued:
  - Expect `nack=1` and the FIFO flushed.
  - Expect exactly one STOP handshake, then `done=1` and the FSM in IDLE.
- Mid-operation checks:
  - Abort while in WAIT: the current command completes, then one STOP is issued.
  - Assert `preset` while `cmd_valid=1`: `cmd_valid` drops immediately and all registers return to their reset values.
